// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access stage. Turns LDR/STR/LDRB/STRB from the
// single-cycle datapath into one req/ack transaction on a variable-latency
// memory bus. It stalls the core while the transaction is in flight and
// reports misaligned word accesses and bus timeouts on MemFault.
//
// Bus handshake: mem_req rises on the edge that leaves IDLE. mem_req and all
// bus outputs (mem_we, mem_addr, mem_wdata, mem_be) then stay stable until a
// cycle in which mem_ack=1 is sampled. mem_ack is a one-cycle completion
// strobe, and mem_rdata is valid only in that cycle. mem_req drops on the
// same edge that samples the ack, or on the edge of a timeout abort. An ack
// seen outside REQ is ignored.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 15  // REQ cycles without ack before abort (1..255)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ByteEn,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        access;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  lane_byte_d;
  logic [31:0] rdata_d;

  assign access     = MemRead | MemWrite;
  assign misaligned = access & ~ByteEn & (ALUResult[1:0] != 2'b00);

  // Lane steering for the request (from the inputs) and for the returned data
  // (from the access shape latched when the request was issued).
  always_comb begin
    be_d        = 4'hF;
    wdata_d     = WriteData;
    lane_byte_d = mem_rdata[7:0];
    if (ByteEn) begin
      be_d    = 4'b0001 << ALUResult[1:0];
      wdata_d = {4{WriteData[7:0]}};
    end
    case (lane_q)
      2'd0:    lane_byte_d = mem_rdata[7:0];
      2'd1:    lane_byte_d = mem_rdata[15:8];
      2'd2:    lane_byte_d = mem_rdata[23:16];
      default: lane_byte_d = mem_rdata[31:24];
    endcase
    rdata_d = byte_q ? {24'b0, lane_byte_d} : mem_rdata;
  end

  // Access FSM with registered bus outputs, timeout counter and fault pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      byte_q  <= 1'b0;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // A misaligned word access never reaches the bus; it only pulses the fault.
          fault_q <= misaligned;
          if (access && !misaligned) begin
            addr_q  <= {ALUResult[31:2], 2'b00};
            we_q    <= MemWrite;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            byte_q  <= ByteEn;
            lane_q  <= ALUResult[1:0];
            req_q   <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 8'd1;
          // The ack is checked first, so an ack on the last allowed cycle still completes.
          if (mem_ack) begin
            req_q <= 1'b0;
            if (!we_q) rdata_q <= rdata_d;
            state_q <= DONE;
          end else if (cnt_q == LAST_CNT) begin
            req_q   <= 1'b0;
            rdata_q <= 32'd0;
            fault_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // The retiring instruction still drives MemRead/MemWrite here, so DONE
          // never looks at them and always returns to IDLE.
          fault_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          fault_q <= 1'b0;
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Stall       = (state_q == REQ) || ((state_q == IDLE) && access && !misaligned);
  assign ReadData    = rdata_q;
  assign MemFault    = fault_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: one task per scenario with inline checks.
module tb_dmem_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, ByteEn;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, MemFault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  // Results of the most recent do_access call.
  int          stall_n, req_n, cyc_n;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  dmem_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .ByteEn(ByteEn),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .MemFault(MemFault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; ByteEn = 0; ALUResult = 0; WriteData = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  // Drive one access from IDLE and act as the bus: ack on REQ cycle ack_at
  // (0 = never). Returns at posedge+1 of the DONE cycle, or after a cycle budget.
  task automatic do_access(input logic rd, input logic wr, input logic be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata);
    MemRead = rd; MemWrite = wr; ByteEn = be; ALUResult = addr; WriteData = wdata;
    mem_ack = 0; mem_rdata = rdata;
    stall_n = 0; req_n = 0; cyc_n = 0;
    #1;
    while (dbg_state_o != S_DONE && cyc_n < 100) begin
      if (Stall) stall_n++;
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be; cap_we = mem_we;
        end
        mem_ack = (req_n == ack_at);
      end else begin
        mem_ack = 0;
      end
      tick();
      cyc_n++;
    end
    mem_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    checks++; if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state_o, S_IDLE); end
    checks++; if ({mem_req, mem_we, MemFault, Stall} !== 4'b0) begin errors++; $display("FAIL reset_flags: req/we/fault/stall got %b want 0000", {mem_req, mem_we, MemFault, Stall}); end
    checks++; if ({ReadData, mem_addr, mem_wdata, mem_be} !== 100'd0) begin errors++; $display("FAIL reset_regs: rd=%h addr=%h wd=%h be=%h want all 0", ReadData, mem_addr, mem_wdata, mem_be); end
  endtask

  task automatic test_word_load();
    do_access(1, 0, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    checks++; if (dbg_state_o !== S_DONE) begin errors++; $display("FAIL wl_done: state %0d want %0d", dbg_state_o, S_DONE); end
    checks++; if (cap_addr !== 32'h100 || cap_be !== 4'hF || cap_we !== 1'b0) begin errors++; $display("FAIL wl_bus: addr=%h be=%h we=%b want 100/f/0", cap_addr, cap_be, cap_we); end
    checks++; if (stall_n !== 4 || req_n !== 3) begin errors++; $display("FAIL wl_latency: stall=%0d req=%0d want 4/3", stall_n, req_n); end
    checks++; if (ReadData !== 32'hDEADBEEF || MemFault !== 0 || Stall !== 0 || mem_req !== 0) begin errors++; $display("FAIL wl_result: rd=%h fault=%b stall=%b req=%b want deadbeef/0/0/0", ReadData, MemFault, Stall, mem_req); end
    // MemRead stays high through the DONE edge: it must not start another access.
    tick();
    checks++; if (dbg_state_o !== S_IDLE || mem_req !== 0) begin errors++; $display("FAIL wl_no_retrigger: state=%0d req=%b want 0/0", dbg_state_o, mem_req); end
    idle_inputs();
  endtask

  task automatic test_byte_access();
    do_access(0, 1, 1, 32'h203, 32'h12345678, 1, 32'h0);
    checks++; if (cap_addr !== 32'h200 || cap_be !== 4'b1000 || cap_wdata !== 32'h78787878 || cap_we !== 1'b1) begin errors++; $display("FAIL bs_bus: addr=%h be=%b wd=%h we=%b want 200/1000/78787878/1", cap_addr, cap_be, cap_wdata, cap_we); end
    checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL bs_rd_hold: rd=%h want deadbeef", ReadData); end
    tick(); idle_inputs();
    do_access(1, 0, 1, 32'h202, 32'h0, 2, 32'hAABBCCDD);
    checks++; if (cap_addr !== 32'h200 || cap_be !== 4'b0100 || cap_we !== 1'b0) begin errors++; $display("FAIL bl_bus: addr=%h be=%b we=%b want 200/0100/0", cap_addr, cap_be, cap_we); end
    checks++; if (ReadData !== 32'h000000BB) begin errors++; $display("FAIL bl_data: rd=%h want 000000bb", ReadData); end
    tick(); idle_inputs();
  endtask

  task automatic test_rw_conflict();
    do_access(1, 1, 0, 32'h500, 32'h0BADCAFE, 1, 32'hFFFFFFFF);
    checks++; if (cap_we !== 1'b1 || cap_wdata !== 32'h0BADCAFE || cap_be !== 4'hF) begin errors++; $display("FAIL rw_bus: we=%b wd=%h be=%h want 1/0badcafe/f", cap_we, cap_wdata, cap_be); end
    checks++; if (ReadData !== 32'h000000BB) begin errors++; $display("FAIL rw_rd_hold: rd=%h want 000000bb", ReadData); end
    tick(); idle_inputs();
  endtask

  task automatic test_misaligned();
    int fault_n;
    logic req_seen;
    fault_n = 0; req_seen = 0;
    MemRead = 1; ByteEn = 0; ALUResult = 32'h102;
    #1;
    checks++; if (Stall !== 0) begin errors++; $display("FAIL mis_stall: got %b want 0", Stall); end
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (MemFault) fault_n++;
      if (mem_req) req_seen = 1;
      tick();
    end
    checks++; if (fault_n !== 1) begin errors++; $display("FAIL mis_fault_pulse: %0d cycles want 1", fault_n); end
    checks++; if (req_seen !== 0 || dbg_state_o !== S_IDLE) begin errors++; $display("FAIL mis_no_bus: req_seen=%b state=%0d want 0/0", req_seen, dbg_state_o); end
    checks++; if (ReadData !== 32'h000000BB) begin errors++; $display("FAIL mis_rd_hold: rd=%h want 000000bb", ReadData); end
  endtask

  task automatic test_timeout();
    do_access(1, 0, 0, 32'h600, 32'h0, 0, 32'h12345678);
    checks++; if (dbg_state_o !== S_DONE || req_n !== 15) begin errors++; $display("FAIL to_req_len: state=%0d req=%0d want 2/15", dbg_state_o, req_n); end
    checks++; if (MemFault !== 1 || ReadData !== 32'h0 || Stall !== 0 || mem_req !== 0) begin errors++; $display("FAIL to_done: fault=%b rd=%h stall=%b req=%b want 1/0/0/0", MemFault, ReadData, Stall, mem_req); end
    tick(); idle_inputs();
    checks++; if (dbg_state_o !== S_IDLE || MemFault !== 0) begin errors++; $display("FAIL to_idle: state=%0d fault=%b want 0/0", dbg_state_o, MemFault); end
    do_access(1, 0, 0, 32'h604, 32'h0, 15, 32'h55AA1234);
    checks++; if (req_n !== 15 || stall_n !== 16) begin errors++; $display("FAIL to_late_ack_len: req=%0d stall=%0d want 15/16", req_n, stall_n); end
    checks++; if (MemFault !== 0 || ReadData !== 32'h55AA1234) begin errors++; $display("FAIL to_late_ack: fault=%b rd=%h want 0/55aa1234", MemFault, ReadData); end
    tick(); idle_inputs();
  endtask

  task automatic test_reset_in_req();
    logic fault_seen;
    fault_seen = 0;
    MemRead = 1; ByteEn = 0; ALUResult = 32'h300;
    tick();
    checks++; if (mem_req !== 1 || dbg_state_o !== S_REQ) begin errors++; $display("FAIL rr_enter: req=%b state=%0d want 1/1", mem_req, dbg_state_o); end
    tick();
    reset = 1;
    tick();
    checks++; if (mem_req !== 0 || dbg_state_o !== S_IDLE || ReadData !== 32'h0 || MemFault !== 0) begin errors++; $display("FAIL rr_abort: req=%b state=%0d rd=%h fault=%b want 0/0/0/0", mem_req, dbg_state_o, ReadData, MemFault); end
    reset = 0; MemRead = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0;
    for (int i = 0; i < 2; i++) begin
      if (MemFault) fault_seen = 1;
      tick();
    end
    checks++; if (mem_req !== 0 || dbg_state_o !== S_IDLE || ReadData !== 32'h0 || fault_seen !== 0) begin errors++; $display("FAIL rr_late_ack: req=%b state=%0d rd=%h fault=%b want 0/0/0/0", mem_req, dbg_state_o, ReadData, fault_seen); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int total_req;
    do_access(1, 0, 0, 32'h400, 32'h0, 1, 32'h11111111);
    total_req = req_n;
    checks++; if (cyc_n !== 2 || stall_n !== 2 || ReadData !== 32'h11111111) begin errors++; $display("FAIL b2b_first: cyc=%0d stall=%0d rd=%h want 2/2/11111111", cyc_n, stall_n, ReadData); end
    checks++; if (mem_req !== 0) begin errors++; $display("FAIL b2b_done_req: got %b want 0", mem_req); end
    tick();
    checks++; if (dbg_state_o !== S_IDLE) begin errors++; $display("FAIL b2b_fresh_idle: state=%0d want 0", dbg_state_o); end
    do_access(1, 0, 0, 32'h404, 32'h0, 1, 32'h22222222);
    total_req = total_req + req_n;
    checks++; if (cyc_n !== 2 || cap_addr !== 32'h404 || ReadData !== 32'h22222222) begin errors++; $display("FAIL b2b_second: cyc=%0d addr=%h rd=%h want 2/404/22222222", cyc_n, cap_addr, ReadData); end
    tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      if (mem_req) total_req++;
      tick();
    end
    checks++; if (total_req !== 2) begin errors++; $display("FAIL b2b_req_count: %0d want 2", total_req); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_word_load();
    test_byte_access();
    test_rw_conflict();
    test_misaligned();
    test_timeout();
    test_reset_in_req();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
